clk_phase_gen: RTL



---
 rtl/clk_div_pkg.sv | 40 ++++
 rtl/clk_div_rst_stretch.sv | 48 ++++
 rtl/clk_phase_gen.sv | 84 ++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared helpers for the multi-phase Johnson clock divider: next-state and
// legality functions (width-generic up to MAX_PHASES) and hold-counter sizing.
package clk_div_pkg;

    localparam int MAX_PHASES = 64;

    // Hold counter needs to represent 0..RST_HOLD; keep at least one bit.
    function automatic int hold_cnt_width(input int rst_hold);
        int w;
        w = $clog2(rst_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [MAX_PHASES-1:0] johnson_next(
        input logic [MAX_PHASES-1:0] q,
        input int                    phases
    );
        logic [MAX_PHASES-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_PHASES; i++) begin
            if (i < phases) r[i] = q[i-1];
        end
        r[0] = ~q[phases-1];
        return r;
    endfunction

    // A legal Johnson word has at most one boundary between runs of 0s and 1s.
    function automatic logic johnson_legal(
        input logic [MAX_PHASES-1:0] q,
        input int                    phases
    );
        int edges;
        edges = 0;
        for (int i = 0; i < MAX_PHASES - 1; i++) begin
            if ((i < phases - 1) && (q[i] != q[i+1])) edges++;
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/clk_div_rst_stretch.sv
// Downstream reset stretcher: holds rst_o high while the divider is stopped and
// for RST_HOLD frame pulses after a run starts; the frame count saturates.
module clk_div_rst_stretch
    import clk_div_pkg::*;
#(
    parameter int RST_HOLD = 3,
    parameter int HOLD_W   = hold_cnt_width(RST_HOLD)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              running,
    input  logic              frame,
    output logic              rst_o,
    output logic [HOLD_W-1:0] hold_cnt_o
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              rst_q, rst_d;

    // running is the divider's next-cycle run state, so rst_o moves in the
    // same cycle as running_o.
    always_comb begin
        cnt_d = cnt_q;
        rst_d = 1'b1;
        if (!running) begin
            cnt_d = '0;
        end else begin
            if (frame && (cnt_q < HOLD_MAX)) cnt_d = cnt_q + 1'b1;
            rst_d = (cnt_d < HOLD_MAX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rst_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            rst_q <= rst_d;
        end
    end

    assign rst_o      = rst_q;
    assign hold_cnt_o = cnt_q;

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-phase Johnson clock divider (divide by 2*PHASES) with clean run/stop,
// frame marker and stretched reset. Optional macro: CLK_PHASE_GEN_SELFCORRECT_EN.
module clk_phase_gen
    import clk_div_pkg::*;
#(
    parameter int PHASES   = 2,
    parameter int RST_HOLD = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [PHASES-1:0] clk_o,
    output logic              frame_o,
    output logic              running_o,
    output logic              rst_o,
    output logic              err_o
);

    localparam int HOLD_W = hold_cnt_width(RST_HOLD);

    logic [PHASES-1:0]     q_q, q_d;
    logic                  running_q, running_d;
    logic [MAX_PHASES-1:0] q_ext, q_adv;
    logic                  advance;
    logic [HOLD_W-1:0]     hold_cnt;
`ifdef CLK_PHASE_GEN_SELFCORRECT_EN
    logic                  err_q, err_d;
`endif

    // A non-zero state always finishes its period, so stopping never truncates a pulse.
    always_comb begin
        q_ext              = '0;
        q_ext[PHASES-1:0]  = q_q;
        q_adv              = johnson_next(q_ext, PHASES);
        advance            = en_i || (q_q != '0);
        q_d                = advance ? q_adv[PHASES-1:0] : q_q;
        running_d          = en_i || (q_d != '0);
`ifdef CLK_PHASE_GEN_SELFCORRECT_EN
        err_d = 1'b0;
        if (!johnson_legal(q_ext, PHASES)) begin
            q_d       = '0;
            running_d = running_q;
            err_d     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q       <= '0;
            running_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            running_q <= running_d;
        end
    end

`ifdef CLK_PHASE_GEN_SELFCORRECT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign clk_o     = q_q;
    assign running_o = running_q;
    assign frame_o   = q_q[0] & ~q_q[1];

    clk_div_rst_stretch #(
        .RST_HOLD (RST_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_rst_stretch (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .running    (running_d),
        .frame      (frame_o),
        .rst_o      (rst_o),
        .hold_cnt_o (hold_cnt)
    );

endmodule
